pe3_feeder: RTL and testbench
=============================

PE3_FEEDER -- requirements
Module: pe3_feeder

Interface
REQ-001 Parameters, one per line: EXPONENT, 8, exponent width; MANTISSA, 23, mantissa width; ROW_LAT, 4, cycles from a 1x3 row's valid to its result (ROW_LAT >= 1). W = 1+EXPONENT+MANTISSA throughout.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ker_valid  input  1; ker_data  input  W; ker_ready  output  1 -- serial kernel-word load handshake.
REQ-005 ker_reload  input  1  level request to replace the loaded kernel.
REQ-006 win_valid  input  1; win_data  input  9W (row r at [3rW +: 3W]); win_ready  output  1 -- 3x3 window handshake.
REQ-007 pe3_array{0,1,2}_valid  output  1 each; pe3_array{0,1,2}_data3  output  3W each; pe3_array{0,1,2}_ker3  output  3W each -- drive the 3-row PE array.
REQ-008 pe3_o  input  W  accumulated result returned by the PE array.
REQ-009 out_valid  output  1; out_data  output  W  result strobe and value.
REQ-010 busy  output  1  high while any window is in flight.

Function
REQ-011 Operating states are LOAD, RUN and DRAIN only.
REQ-012 LOAD: ker_ready=1, win_ready=0; on each ker handshake word k (k=0..8, 4-bit counter) is stored to row k/3 at bit offset (k%3)*W; after k=8 the counter clears and the state moves to RUN next cycle.
REQ-013 RUN: win_ready = !ker_reload; ker_ready=0.
REQ-014 On a window handshake at edge t: pe3_array0_valid=1 with row-0 data in the cycle after t; row 1 follows ROW_LAT cycles later and row 2 follows 2*ROW_LAT cycles later, using delay lines; back-to-back accepts every cycle are legal.
REQ-015 out_valid is pe3_array2_valid delayed ROW_LAT cycles; out_data = pe3_o whenever out_valid=1; out_valid rises 3*ROW_LAT+1 cycles after the accepting edge.
REQ-016 An in-flight counter is incremented on accept and decremented on out_valid, and is unchanged when both occur in one cycle; busy = (count != 0).
REQ-017 ker_reload=1 in RUN moves the state to DRAIN; in DRAIN win_ready=0, and the state moves to LOAD in the cycle after the count is 0.
REQ-018 ker_reload is ignored in LOAD and in DRAIN.
REQ-019 When a row valid is 0, its data3 holds the last issued value; ker3 outputs change only in LOAD.
REQ-020 A ker handshake outside LOAD has no effect; a win handshake is impossible outside RUN.

Reset
REQ-021 On rst_n=0 and asynchronously, the following are cleared:
- state = LOAD; counters = 0;
- delay lines, valids, data3, ker3, out_valid and out_data = 0;
- busy = 0.
REQ-022 Windows in flight at reset are discarded; no out_valid follows reset for them.

Configuration
REQ-023 With PE3_FEEDER_OUTREG_EN defined, out_valid/out_data are registered, adding exactly 1 cycle (strobe at 3*ROW_LAT+2), and busy/count are decremented on the registered strobe. Without it, REQ-015 timing holds combinationally from pe3_o.

Verification
REQ-024 Bench uses ROW_LAT=2: after reset, load words 1..9 -> ker3 rows = {3,2,1},{6,5,4},{9,8,7} (high..low); state RUN after the 9th.
REQ-025 One window accepted at cycle 10 -> array0_valid at 11, array1_valid at 13, array2_valid at 15, out_valid at 17 carrying pe3_o.
REQ-026 Five back-to-back windows -> five consecutive out_valid pulses; busy=1 from the first accept until after the fifth strobe; count peaks at 5 or fewer.
REQ-027 ker_reload raised with 3 windows in flight -> win_ready drops the same cycle, all 3 results still emerge, then LOAD the next cycle with ker_ready=1.
REQ-028 rst_n pulsed low mid-stream with 4 windows in flight -> all outputs 0 immediately, no later out_valid, state LOAD.
REQ-029 Build with PE3_FEEDER_OUTREG_EN -> REQ-025 out_valid moves to cycle 18 with identical data.

Source files
------------

// File: rtl/pe3_feeder.sv
// Feeds a 3-row PE array: serial 3x3 kernel load, then skewed row issue per accepted window.
// Optional build macro PE3_FEEDER_OUTREG_EN adds one register stage on out_valid/out_data.
module pe3_feeder #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23,
  parameter int ROW_LAT  = 4
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   ker_valid,
  input  logic [EXPONENT+MANTISSA:0]             ker_data,
  output logic                                   ker_ready,
  input  logic                                   ker_reload,
  input  logic                                   win_valid,
  input  logic [9*(1+EXPONENT+MANTISSA)-1:0]     win_data,
  output logic                                   win_ready,
  output logic                                   pe3_array0_valid,
  output logic [3*(1+EXPONENT+MANTISSA)-1:0]     pe3_array0_data3,
  output logic [3*(1+EXPONENT+MANTISSA)-1:0]     pe3_array0_ker3,
  output logic                                   pe3_array1_valid,
  output logic [3*(1+EXPONENT+MANTISSA)-1:0]     pe3_array1_data3,
  output logic [3*(1+EXPONENT+MANTISSA)-1:0]     pe3_array1_ker3,
  output logic                                   pe3_array2_valid,
  output logic [3*(1+EXPONENT+MANTISSA)-1:0]     pe3_array2_data3,
  output logic [3*(1+EXPONENT+MANTISSA)-1:0]     pe3_array2_ker3,
  input  logic [EXPONENT+MANTISSA:0]             pe3_o,
  output logic                                   out_valid,
  output logic [EXPONENT+MANTISSA:0]             out_data,
  output logic                                   busy
);

  localparam int W  = 1 + EXPONENT + MANTISSA;
  localparam int L1 = ROW_LAT;
  localparam int L2 = 2 * ROW_LAT;
  localparam int CW = $clog2(3 * ROW_LAT + 4) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [3:0]      kcnt_r;
  logic [1:0]      kr_s;
  logic [1:0]      kc_s;
  logic            ker_fire_s;
  logic            win_fire_s;
  logic            strobe_s;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_s;
  logic [3*W-1:0]  ker_row_r [3];

  logic            v1_line_r [L1];
  logic [3*W-1:0]  d1_line_r [L1];
  logic            v2_line_r [L2];
  logic [3*W-1:0]  d2_line_r [L2];
  logic            vo_line_r [L1];

  assign ker_fire_s = ker_valid && (state_r == ST_LOAD);
  assign win_fire_s = win_valid && (state_r == ST_RUN) && !ker_reload;
  assign kr_s       = 2'(kcnt_r / 4'd3);
  assign kc_s       = 2'(kcnt_r % 4'd3);

  assign pe3_array0_ker3 = ker_row_r[0];
  assign pe3_array1_ker3 = ker_row_r[1];
  assign pe3_array2_ker3 = ker_row_r[2];

  // Next-state and handshake readiness
  always_comb begin
    state_s   = state_r;
    ker_ready = 1'b0;
    win_ready = 1'b0;
    case (state_r)
      ST_LOAD: begin
        ker_ready = 1'b1;
        if (ker_fire_s && (kcnt_r == 4'd8)) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_LOAD;
        end
      end
      ST_RUN: begin
        win_ready = !ker_reload;
        if (ker_reload) begin
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == CNT_ZERO) begin
          state_s = ST_LOAD;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: begin
        state_s = ST_LOAD;
      end
    endcase
  end

  // In-flight count; simultaneous accept and retire cancel out
  always_comb begin
    cnt_s = cnt_r;
    if (win_fire_s && !strobe_s) begin
      cnt_s = cnt_r + CNT_ONE;
    end else if (!win_fire_s && strobe_s) begin
      cnt_s = cnt_r - CNT_ONE;
    end else begin
      cnt_s = cnt_r;
    end
  end

  // State, counters and busy flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_LOAD;
      cnt_r   <= CNT_ZERO;
      busy    <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      busy    <= (cnt_s != CNT_ZERO);
    end
  end

  // Kernel word capture; row k/3, slot k%3
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kcnt_r <= 4'd0;
      for (int r = 0; r < 3; r++) begin
        ker_row_r[r] <= {(3*W){1'b0}};
      end
    end else if (ker_fire_s) begin
      ker_row_r[kr_s][kc_s*W +: W] <= ker_data;
      kcnt_r <= (kcnt_r == 4'd8) ? 4'd0 : kcnt_r + 4'd1;
    end else begin
      kcnt_r <= kcnt_r;
    end
  end

  // Row 0 issues directly; rows 1 and 2 ride delay lines of ROW_LAT and 2*ROW_LAT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < L1; i++) begin
        v1_line_r[i] <= 1'b0;
        d1_line_r[i] <= {(3*W){1'b0}};
        vo_line_r[i] <= 1'b0;
      end
      for (int i = 0; i < L2; i++) begin
        v2_line_r[i] <= 1'b0;
        d2_line_r[i] <= {(3*W){1'b0}};
      end
    end else begin
      v1_line_r[0] <= win_fire_s;
      v2_line_r[0] <= win_fire_s;
      vo_line_r[0] <= pe3_array2_valid;
      if (win_fire_s) begin
        d1_line_r[0] <= win_data[3*W +: 3*W];
        d2_line_r[0] <= win_data[6*W +: 3*W];
      end else begin
        d1_line_r[0] <= d1_line_r[0];
        d2_line_r[0] <= d2_line_r[0];
      end
      for (int i = 1; i < L1; i++) begin
        v1_line_r[i] <= v1_line_r[i-1];
        d1_line_r[i] <= d1_line_r[i-1];
        vo_line_r[i] <= vo_line_r[i-1];
      end
      for (int i = 1; i < L2; i++) begin
        v2_line_r[i] <= v2_line_r[i-1];
        d2_line_r[i] <= d2_line_r[i-1];
      end
    end
  end

  // Array-facing registers; data3 holds the last issued row between valids
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pe3_array0_valid <= 1'b0;
      pe3_array1_valid <= 1'b0;
      pe3_array2_valid <= 1'b0;
      pe3_array0_data3 <= {(3*W){1'b0}};
      pe3_array1_data3 <= {(3*W){1'b0}};
      pe3_array2_data3 <= {(3*W){1'b0}};
    end else begin
      pe3_array0_valid <= win_fire_s;
      pe3_array1_valid <= v1_line_r[L1-1];
      pe3_array2_valid <= v2_line_r[L2-1];
      if (win_fire_s) begin
        pe3_array0_data3 <= win_data[0 +: 3*W];
      end else begin
        pe3_array0_data3 <= pe3_array0_data3;
      end
      if (v1_line_r[L1-1]) begin
        pe3_array1_data3 <= d1_line_r[L1-1];
      end else begin
        pe3_array1_data3 <= pe3_array1_data3;
      end
      if (v2_line_r[L2-1]) begin
        pe3_array2_data3 <= d2_line_r[L2-1];
      end else begin
        pe3_array2_data3 <= pe3_array2_data3;
      end
    end
  end

`ifdef PE3_FEEDER_OUTREG_EN
  // Registered result strobe; retirement counts on this delayed strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= {W{1'b0}};
    end else begin
      out_valid <= vo_line_r[L1-1];
      if (vo_line_r[L1-1]) begin
        out_data <= pe3_o;
      end else begin
        out_data <= out_data;
      end
    end
  end
  assign strobe_s = out_valid;
`else
  assign out_valid = vo_line_r[L1-1];
  assign out_data  = vo_line_r[L1-1] ? pe3_o : {W{1'b0}};
  assign strobe_s  = vo_line_r[L1-1];
`endif

endmodule

// File: tb/tb_pe3_feeder.sv
// Scoreboard bench for pe3_feeder with ROW_LAT=2; the bench plays the PE array by
// driving pe3_o as a known function of the cycle number.
module tb_pe3_feeder;

  localparam int EXP = 8;
  localparam int MAN = 23;
  localparam int RL  = 2;
  localparam int W   = 1 + EXP + MAN;
`ifdef PE3_FEEDER_OUTREG_EN
  localparam int OX = 1;
`else
  localparam int OX = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ker_valid;
  logic [W-1:0]    ker_data;
  logic            ker_ready;
  logic            ker_reload;
  logic            win_valid;
  logic [9*W-1:0]  win_data;
  logic            win_ready;
  logic            a0_v, a1_v, a2_v;
  logic [3*W-1:0]  a0_d, a1_d, a2_d, a0_k, a1_k, a2_k;
  logic [W-1:0]    pe3_o;
  logic            out_valid;
  logic [W-1:0]    out_data;
  logic            busy;

  pe3_feeder #(.EXPONENT(EXP), .MANTISSA(MAN), .ROW_LAT(RL)) dut (
    .clk(clk), .rst_n(rst_n),
    .ker_valid(ker_valid), .ker_data(ker_data), .ker_ready(ker_ready),
    .ker_reload(ker_reload),
    .win_valid(win_valid), .win_data(win_data), .win_ready(win_ready),
    .pe3_array0_valid(a0_v), .pe3_array0_data3(a0_d), .pe3_array0_ker3(a0_k),
    .pe3_array1_valid(a1_v), .pe3_array1_data3(a1_d), .pe3_array1_ker3(a1_k),
    .pe3_array2_valid(a2_v), .pe3_array2_data3(a2_d), .pe3_array2_ker3(a2_k),
    .pe3_o(pe3_o), .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] resf(input int c);
    return 32'hC0DE_0000 ^ 32'(c);
  endfunction

  assign pe3_o = resf(cyc);

  typedef struct {
    int             cyc;
    logic [3*W-1:0] d;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], qo[$];
  int checks = 0;
  int errors = 0;
  int model_cnt = 0;
  int strobes = 0;

  // Monitor: predicts on accept, compares on every DUT strobe
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checks++;
      if (busy !== (model_cnt != 0)) begin
        errors++;
        $display("FAIL busy cyc=%0d got %b exp %b", cyc, busy, model_cnt != 0);
      end
      if (a0_v) begin
        checks++;
        if (q0.size() == 0) begin
          errors++; $display("FAIL row0_unexpected cyc=%0d", cyc);
        end else begin
          e = q0.pop_front();
          if (cyc != e.cyc || a0_d !== e.d) begin
            errors++;
            $display("FAIL row0 got cyc=%0d d=%h exp cyc=%0d d=%h", cyc, a0_d, e.cyc, e.d);
          end
        end
      end
      if (a1_v) begin
        checks++;
        if (q1.size() == 0) begin
          errors++; $display("FAIL row1_unexpected cyc=%0d", cyc);
        end else begin
          e = q1.pop_front();
          if (cyc != e.cyc || a1_d !== e.d) begin
            errors++;
            $display("FAIL row1 got cyc=%0d d=%h exp cyc=%0d d=%h", cyc, a1_d, e.cyc, e.d);
          end
        end
      end
      if (a2_v) begin
        checks++;
        if (q2.size() == 0) begin
          errors++; $display("FAIL row2_unexpected cyc=%0d", cyc);
        end else begin
          e = q2.pop_front();
          if (cyc != e.cyc || a2_d !== e.d) begin
            errors++;
            $display("FAIL row2 got cyc=%0d d=%h exp cyc=%0d d=%h", cyc, a2_d, e.cyc, e.d);
          end
        end
      end
      if (out_valid) begin
        checks++;
        strobes++;
        if (qo.size() == 0) begin
          errors++; $display("FAIL out_unexpected cyc=%0d", cyc);
        end else begin
          e = qo.pop_front();
          if (cyc != e.cyc || out_data !== e.d[W-1:0]) begin
            errors++;
            $display("FAIL out got cyc=%0d d=%h exp cyc=%0d d=%h", cyc, out_data, e.cyc, e.d[W-1:0]);
          end
        end
        model_cnt--;
      end
      if (win_valid && win_ready) begin
        e.cyc = cyc + 1;          e.d = win_data[0 +: 3*W];   q0.push_back(e);
        e.cyc = cyc + 1 + RL;     e.d = win_data[3*W +: 3*W]; q1.push_back(e);
        e.cyc = cyc + 1 + 2*RL;   e.d = win_data[6*W +: 3*W]; q2.push_back(e);
        e.cyc = cyc + 3*RL + 1 + OX;
        e.d   = {{(2*W){1'b0}}, resf(cyc + 3*RL + 1)};
        qo.push_back(e);
        model_cnt++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_kernel(input int base);
    for (int k = 0; k < 9; k++) begin
      ker_valid = 1'b1;
      ker_data  = 32'(base + k);
      step(1);
    end
    ker_valid = 1'b0;
  endtask

  task automatic rand_window();
    for (int i = 0; i < 9; i++) win_data[i*W +: W] = $urandom;
  endtask

  task automatic wait_not_busy(input int max);
    int n = 0;
    while (busy && n < max) begin
      step(1);
      n++;
    end
    checks++;
    if (busy) begin
      errors++; $display("FAIL busy_timeout got 1 exp 0");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ker_valid = 1'b0; ker_data = '0; ker_reload = 1'b0;
    win_valid = 1'b0; win_data = '0;
    #1;
    checks++;
    if ({a0_v, a1_v, a2_v, out_valid, busy} !== 5'b0 || {a0_d, a1_d, a2_d} !== '0
        || {a0_k, a1_k, a2_k} !== '0 || out_data !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero exp zero");
    end
    checks++;
    if (ker_ready !== 1'b1 || win_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready got ker=%b win=%b exp ker=1 win=0", ker_ready, win_ready);
    end
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_load();
    load_kernel(1);
    checks++;
    if (a0_k !== {32'd3, 32'd2, 32'd1} || a1_k !== {32'd6, 32'd5, 32'd4} || a2_k !== {32'd9, 32'd8, 32'd7}) begin
      errors++; $display("FAIL ker3 got %h %h %h exp rows 321 654 987", a0_k, a1_k, a2_k);
    end
    checks++;
    if (ker_ready !== 1'b0 || win_ready !== 1'b1) begin
      errors++; $display("FAIL run_ready got ker=%b win=%b exp ker=0 win=1", ker_ready, win_ready);
    end
    ker_valid = 1'b1; ker_data = 32'd99;
    step(1);
    ker_valid = 1'b0;
    checks++;
    if (a0_k !== {32'd3, 32'd2, 32'd1} || a2_k !== {32'd9, 32'd8, 32'd7}) begin
      errors++; $display("FAIL ker_outside_load got %h %h exp unchanged", a0_k, a2_k);
    end
  endtask

  task automatic test_single();
    rand_window();
    win_valid = 1'b1;
    step(1);
    win_valid = 1'b0;
    step(3*RL + 4);
    checks++;
    if (qo.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_done got pending=%0d busy=%b exp 0 0", qo.size(), busy);
    end
  endtask

  task automatic test_back_to_back();
    int s0 = strobes;
    for (int i = 0; i < 5; i++) begin
      rand_window();
      win_valid = 1'b1;
      step(1);
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL b2b_busy i=%0d got %b exp 1", i, busy);
      end
    end
    win_valid = 1'b0;
    wait_not_busy(40);
    checks++;
    if (strobes - s0 != 5 || qo.size() != 0) begin
      errors++; $display("FAIL b2b_count got %0d exp 5", strobes - s0);
    end
  endtask

  task automatic test_reload_drain();
    int s0 = strobes;
    for (int i = 0; i < 3; i++) begin
      rand_window();
      win_valid = 1'b1;
      step(1);
    end
    ker_reload = 1'b1;
    #1;
    checks++;
    if (win_ready !== 1'b0) begin
      errors++; $display("FAIL reload_ready got %b exp 0", win_ready);
    end
    wait_not_busy(40);
    checks++;
    if (strobes - s0 != 3 || ker_ready !== 1'b0) begin
      errors++; $display("FAIL drain got strobes=%0d ker_ready=%b exp 3 0", strobes - s0, ker_ready);
    end
    step(1);
    checks++;
    if (ker_ready !== 1'b1 || win_ready !== 1'b0) begin
      errors++; $display("FAIL drain_to_load got ker=%b win=%b exp 1 0", ker_ready, win_ready);
    end
    step(1);
    checks++;
    if (ker_ready !== 1'b1) begin
      errors++; $display("FAIL reload_in_load got ker=%b exp 1", ker_ready);
    end
    ker_reload = 1'b0;
    win_valid  = 1'b0;
    load_kernel(11);
    checks++;
    if (a0_k !== {32'd13, 32'd12, 32'd11} || a2_k !== {32'd19, 32'd18, 32'd17} || win_ready !== 1'b1) begin
      errors++; $display("FAIL reload_ker3 got %h %h exp rows 13-11 19-17", a0_k, a2_k);
    end
  endtask

  task automatic test_midstream_reset();
    int s0;
    for (int i = 0; i < 4; i++) begin
      rand_window();
      win_valid = 1'b1;
      step(1);
    end
    win_valid = 1'b0;
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete(); qo.delete();
    model_cnt = 0;
    #1;
    checks++;
    if ({a0_v, a1_v, a2_v, out_valid, busy} !== 5'b0 || {a0_d, a1_d, a2_d, a0_k} !== '0 || out_data !== '0) begin
      errors++; $display("FAIL midreset_outputs got nonzero exp zero");
    end
    step(1);
    rst_n = 1'b1;
    s0 = strobes;
    step(3*RL + 6);
    checks++;
    if (strobes != s0 || ker_ready !== 1'b1 || win_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_after got strobes=%0d ker=%b exp 0 1", strobes - s0, ker_ready);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_single();
    test_back_to_back();
    test_reload_drain();
    test_single();
    test_midstream_reset();
    checks++;
    if (q0.size() + q1.size() + q2.size() + qo.size() != 0) begin
      errors++; $display("FAIL leftover got %0d exp 0", q0.size() + q1.size() + q2.size() + qo.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
